map_collision_scheduler: RTL and testbench
==========================================

Name: map_collision_scheduler

Overview:
- Shares the single combinational tile-map wall lookup among NUM_REQ sprite requesters (player car, enemy cars) using round-robin arbitration.
- For each granted request, probes the four corners of a SPRITE_SIZE square sprite, one corner per cycle, and returns a one-bit hit per requester.
- Owns the active level_id register that drives the map instance. A level change is applied only when no probe is in flight.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SPRITE_SIZE, 32, sprite edge in pixels. Corners are at x / x+SPRITE_SIZE-1 and y / y+SPRITE_SIZE-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester query request. Level-held until done.
- req_x  in  NUM_REQ*10  flattened sprite top-left x. Slice i is [10*i+9:10*i].
- req_y  in  NUM_REQ*10  flattened sprite top-left y.
- level_load  in  1  one-cycle strobe that requests a level change.
- level_in  in  2  new level value.
- map_is_wall  in  1  combinational wall result from the map instance.
- map_x  out  10  pixel x presented to the map.
- map_y  out  10  pixel y presented to the map.
- level_id  out  2  active level, wired to the map.
- grant  out  NUM_REQ  one-hot owner of the current query.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- hit  out  NUM_REQ  last result per requester, updated with done.
- busy  out  1  high in PROBE and DONE states.

Behaviour:
- Reset: all outputs are 0; FSM=IDLE; rr pointer=0; pending-level flag cleared; level_id=0.
- FSM states: IDLE -> PROBE -> DONE -> IDLE.
- IDLE:
  - If a level change is pending: level_id<=pending value, clear the pending flag, no grant this cycle.
  - Otherwise, if any req is set: pick the first set bit at or after the rr pointer (wrapping). Latch its x/y, set grant, corner<=0, go to PROBE.
- PROBE: corner counter 0..3 selects (x,y), (x+S-1,y), (x,y+S-1), (x+S-1,y+S-1).
  - Corner sums are computed in 11 bits.
  - A corner with x>=640 or y>=480 counts as a wall without using map_is_wall. map_x/map_y are still driven, truncated to 10 bits.
  - The hit accumulator ORs in the result each cycle; map_is_wall is sampled in the same cycle map_x/map_y are driven.
  - After corner 3, go to DONE.
- DONE:
  - done[i] pulses; hit[i]<=accumulator; hit for other requesters is unchanged.
  - rr pointer<=i+1 mod NUM_REQ; grant cleared on exit; next state IDLE.
- Latency: request sampled in IDLE at cycle t; corners at t+1..t+4; done at t+5; IDLE again at t+6. Back-to-back throughput is 1 query per 6 cycles.
- Requesters drop req the cycle after done. A req still high at t+6 is re-arbitrated behind the others.
- req dropped mid-probe: the probe completes; done and hit are still issued to that requester.
- level_load in any state: captured into the pending register; a later strobe overwrites it. level_id never changes during PROBE or DONE.
- level_load with pending flag set and FSM in IDLE in the same cycle: the new value wins and is applied next IDLE cycle.
- map_x/map_y hold 0 when not in PROBE.
- reset mid-probe: immediate return to IDLE; done is not pulsed.

Optional Feature:
- Macro: COLLISION_EARLY_EXIT_EN.
- Defined: PROBE goes to DONE on the first wall corner, so latency is 2..5 cycles to done.
- Undefined: all four corners are always probed, giving a fixed 5-cycle latency.
- hit values are identical in both builds.

Decomposition:
- Shared package/include map_pkg holds:
  - SCREEN_W=640, SCREEN_H=480, TILE_SHIFT=5.
  - FSM state encodings (IDLE/PROBE/DONE).
  - 2-bit corner index constants.
- Sub-module rr_arbiter (NUM_REQ, req, pointer -> one-hot grant, combinational) is reused by later shared-resource blocks.

Test Plan:
- Level 1 (load 1, wait 1 IDLE cycle), req[0] at (300,200): corner x=331 is gx=10, gy=6 -> done[0] at t+5, hit[0]=1.
- Level 1, req[1] at (100,100): all corners in gx 3..4, gy 3..4 -> hit[1]=0, hit[0] unchanged.
- Off-screen: req[2] at (100,470): y+31=501>=480 -> hit[2]=1 even with map_is_wall forced 0.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0, each done spaced 6 cycles apart.
- Mid-query level_load=2 during PROBE: level_id stays 1 until the IDLE cycle after done, then becomes 2; no grant in that cycle.
- Reset asserted at the second PROBE cycle -> the next cycle has all outputs 0, no done pulse, and the next grant goes to requester 0.

Source files
------------

// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
// Module   : map_pkg
// Purpose  : Shared constants for the tile-map collision blocks: screen
//            geometry, tile size, scheduler state encodings and sprite
//            corner indices, plus a one-hot to index helper.
// Revision : 1.0 - initial release
// ============================================================================
package map_pkg;

  // Visible playfield; anything at or beyond these is treated as solid.
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  // Tiles are 32x32 pixels.
  localparam int unsigned TILE_SHIFT = 5;

  // Width of requester index / round-robin pointer (supports up to 8).
  localparam int unsigned IDX_W = 3;

  // Scheduler state encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROBE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Corner index: bit 0 selects the right edge, bit 1 the bottom edge.
  localparam logic [1:0] CORNER_TL = 2'd0;
  localparam logic [1:0] CORNER_TR = 2'd1;
  localparam logic [1:0] CORNER_BL = 2'd2;
  localparam logic [1:0] CORNER_BR = 2'd3;

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Grants the first set request
//            at or after the pointer, wrapping around to bit 0.
// Ports    : req_i   [NUM_REQ] request vector
//            ptr_i   [IDX_W]   highest-priority index (must be < NUM_REQ)
//            grant_o [NUM_REQ] one-hot grant, zero when no request
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import map_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_pick;

  // Requests at or above the pointer take priority; if none, wrap to the
  // full vector. The lowest set bit of the chosen set is isolated with the
  // x & -x trick.
  always_comb begin
    w_mask  = ~((ONE << ptr_i) - ONE);
    w_hi    = req_i & w_mask;
    w_pick  = (|w_hi) ? w_hi : req_i;
    grant_o = w_pick & (~w_pick + ONE);
  end

endmodule
`default_nettype wire

// File: rtl/map_collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : map_collision_scheduler
// Purpose  : Time-shares the combinational tile-map wall lookup among
//            NUM_REQ sprite requesters. Each granted query probes the four
//            corners of a SPRITE_SIZE square, one per cycle, and reports a
//            single hit bit. Also owns the active level register; level
//            changes are deferred until no probe is in flight.
// Build    : COLLISION_EARLY_EXIT_EN - end the probe on the first wall corner.
// Ports    : clk, reset              clock, synchronous active-high reset
//            req        [NUM_REQ]    level-held query requests
//            req_x/req_y[NUM_REQ*10] flattened sprite top-left coordinates
//            level_load, level_in    level change strobe and value
//            map_is_wall             combinational map result
//            map_x, map_y            probed pixel (0 outside PROBE)
//            level_id                active level to the map
//            grant      [NUM_REQ]    one-hot owner of the current query
//            done       [NUM_REQ]    one-cycle completion pulse
//            hit        [NUM_REQ]    latest result per requester
//            busy                    high in PROBE and DONE
// Revision : 1.0 - initial release
// ============================================================================
module map_collision_scheduler
  import map_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SPRITE_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_x,
  input  logic [NUM_REQ*10-1:0] req_y,
  input  logic                  level_load,
  input  logic [1:0]            level_in,
  input  logic                  map_is_wall,
  output logic [9:0]            map_x,
  output logic [9:0]            map_y,
  output logic [1:0]            level_id,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    hit,
  output logic                  busy
);

  localparam logic [10:0] OFS = 11'(SPRITE_SIZE - 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, hit_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [9:0]         x_q, y_q;
  logic [1:0]         corner_q;
  logic               acc_q;
  logic [1:0]         level_q, pend_val_q;
  logic               pend_q;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [9:0]         w_sel_x, w_sel_y;
  logic [10:0]        w_cx, w_cy;
  logic               w_wall;
  logic               w_start;
  logic               w_last;
  logic [IDX_W-1:0]   w_gidx, w_ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (w_arb_grant)
  );

  // Coordinates of the winning requester.
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_sel_x = req_x[10*i +: 10];
        w_sel_y = req_y[10*i +: 10];
      end
    end
  end

  // A pending level change owns the IDLE cycle, so no grant is issued then.
  assign w_start = (state_q == ST_IDLE) && !pend_q && (|req);

  // Corner sums kept at 11 bits so off-screen corners are detected before
  // the 10-bit truncation presented to the map.
  always_comb begin
    w_cx   = {1'b0, x_q} + (corner_q[0] ? OFS : 11'd0);
    w_cy   = {1'b0, y_q} + (corner_q[1] ? OFS : 11'd0);
    w_wall = (w_cx >= 11'(SCREEN_W)) || (w_cy >= 11'(SCREEN_H)) || map_is_wall;
  end

`ifdef COLLISION_EARLY_EXIT_EN
  assign w_last = (corner_q == CORNER_BR) || w_wall;
`else
  assign w_last = (corner_q == CORNER_BR);
`endif

  assign w_gidx     = onehot_to_idx(8'(grant_q));
  assign w_ptr_next = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + IDX_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_start) state_d = ST_PROBE;
      ST_PROBE: if (w_last)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    map_x = '0;
    map_y = '0;
    done  = '0;
    busy  = 1'b0;
    case (state_q)
      ST_PROBE: begin
        map_x = w_cx[9:0];
        map_y = w_cy[9:0];
        busy  = 1'b1;
      end
      ST_DONE: begin
        done = grant_q;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Query datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      corner_q <= CORNER_TL;
      acc_q    <= 1'b0;
      hit_q    <= '0;
      ptr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            grant_q  <= w_arb_grant;
            x_q      <= w_sel_x;
            y_q      <= w_sel_y;
            corner_q <= CORNER_TL;
            acc_q    <= 1'b0;
          end
        end
        ST_PROBE: begin
          corner_q <= corner_q + 2'd1;
          acc_q    <= acc_q | w_wall;
          // Result lands together with the done pulse; other bits hold.
          if (w_last) begin
            hit_q <= (hit_q & ~grant_q) | ({NUM_REQ{acc_q | w_wall}} & grant_q);
          end
        end
        ST_DONE: begin
          grant_q <= '0;
          ptr_q   <= w_ptr_next;
        end
        default: ;
      endcase
    end
  end

  // Level register. A fresh strobe always overwrites the pending value and
  // keeps the flag set, so it takes precedence over applying an older one.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q    <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else if (level_load) begin
      pend_q     <= 1'b1;
      pend_val_q <= level_in;
    end else if ((state_q == ST_IDLE) && pend_q) begin
      pend_q  <= 1'b0;
      level_q <= pend_val_q;
    end
  end

  assign grant    = grant_q;
  assign hit      = hit_q;
  assign level_id = level_q;

endmodule
`default_nettype wire

// File: tb/tb_map_collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_collision_scheduler
// Purpose  : Scoreboard bench for map_collision_scheduler. A tile-map model
//            answers the DUT's lookups; expected results are computed from
//            sprite corners and pushed when stimulus is issued, and a monitor
//            pops them whenever done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_collision_scheduler;

  localparam int N = 4;
  localparam int S = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*10-1:0] req_x = '0;
  logic [N*10-1:0] req_y = '0;
  logic           level_load = 1'b0;
  logic [1:0]     level_in = '0;
  logic           map_is_wall;
  logic [9:0]     map_x, map_y;
  logic [1:0]     level_id;
  logic [N-1:0]   grant, done, hit;
  logic           busy;

  bit force0 = 1'b0;

  typedef struct {
    int idx;
    int hit;
    int cyc;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cx[N];
  int cy[N];
  int m_ptr = 0, m_level = 0, m_pend = 0, m_pend_val = 0, m_done = -100;
  logic [N-1:0] m_hitv = '0;
  int burst_left = 0;

  map_collision_scheduler #(.NUM_REQ(N), .SPRITE_SIZE(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .level_load  (level_load),
    .level_in    (level_in),
    .map_is_wall (map_is_wall),
    .map_x       (map_x),
    .map_y       (map_y),
    .level_id    (level_id),
    .grant       (grant),
    .done        (done),
    .hit         (hit),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tile map: 32x32 tiles, a different wall layout per level.
  function automatic bit wall_fn(int lvl, int x, int y);
    int gx, gy;
    gx = x / 32;
    gy = y / 32;
    case (lvl)
      0:       return (gx == 0) || (gy == 0);
      1:       return (gx == 10) && (gy >= 2) && (gy <= 12);
      2:       return (gy == 8) && (gx >= 3);
      default: return ((gx + gy) % 4) == 0;
    endcase
  endfunction

  assign map_is_wall = force0 ? 1'b0 : wall_fn(int'(level_id), int'(map_x), int'(map_y));

  // Any of the four corners off-screen or on a wall tile.
  function automatic int corner_hit(int lvl, int x, int y);
    int h, px, py;
    h = 0;
    for (int c = 0; c < 4; c++) begin
      px = x + (((c % 2) == 1) ? S - 1 : 0);
      py = y + (((c / 2) == 1) ? S - 1 : 0);
      if (px >= 640 || py >= 480) h = 1;
      else if (!force0 && wall_fn(lvl, px, py)) h = 1;
    end
    return h;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_coord(input int i, input int x, input int y);
    cx[i] = x;
    cy[i] = y;
    req_x[10*i +: 10] = 10'(x);
    req_y[10*i +: 10] = 10'(y);
  endtask

  // Raise the requests in mask and queue the expected completions. With
  // hold>0 the requests stay high for that many completions.
  task automatic issue(input logic [N-1:0] mask, input int hold);
    int s, p, n, idx;
    logic [N-1:0] pset;
    exp_t e;
    s = (cyc > m_done + 1) ? cyc : m_done + 1;
    if (m_pend != 0) begin
      if (s == m_done + 1) s++;
      m_level = m_pend_val;
      m_pend  = 0;
    end
    pset = mask;
    p    = m_ptr;
    n    = 0;
    if (hold > 0) n = hold;
    else for (int j = 0; j < N; j++) if (mask[j]) n++;
    for (int k = 0; k < n; k++) begin
      idx = -1;
      for (int off = 0; off < N; off++) begin
        if (idx < 0 && pset[(p + off) % N]) idx = (p + off) % N;
      end
      e.idx = idx;
      e.hit = corner_hit(m_level, cx[idx], cy[idx]);
      e.cyc = s + 5;
      sb.push_back(e);
      m_done = s + 5;
      s += 6;
      p = (idx + 1) % N;
      if (hold == 0) pset[idx] = 1'b0;
    end
    m_ptr      = p;
    burst_left = hold;
    req        = req | mask;
  endtask

  task automatic level_pulse(input int v);
    level_load = 1'b1;
    level_in   = 2'(v);
    m_pend     = 1;
    m_pend_val = v;
    @(negedge clk);
    level_load = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("wait_done_timeout", sb.size(), 0);
  endtask

  // Monitor: compare every completion against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          m_hitv[e.idx] = e.hit[0];
          check("done_onehot", int'(done), 1 << e.idx);
          check("grant_at_done", int'(grant), 1 << e.idx);
          check("hit_vector", int'(hit), int'(m_hitv));
`ifndef COLLISION_EARLY_EXIT_EN
          check("done_cycle", cyc, e.cyc);
`endif
          if (burst_left > 0) begin
            burst_left--;
            if (burst_left == 0) req = '0;
          end else begin
            req[e.idx] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s, i;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_map_x", int'(map_x), 0);
    check("rst_map_y", int'(map_y), 0);
    check("rst_level", int'(level_id), 0);

    // Level change while idle takes one IDLE cycle.
    level_pulse(1);
    check("level_pending_not_yet", int'(level_id), 0);
    @(negedge clk);
    check("level_applied", int'(level_id), 1);

    // Corner x=331 lands on the level-1 wall column.
    set_coord(0, 300, 200);
    issue(4'b0001, 0);
    @(negedge clk);
    check("busy_in_probe", int'(busy), 1);
    check("map_x_corner0", int'(map_x), 300);
    wait_idle();

    // Clear area; hit[0] must stay set.
    set_coord(1, 100, 100);
    issue(4'b0010, 0);
    wait_idle();

    // Bottom edge off-screen with the map forced clear.
    force0 = 1'b1;
    set_coord(2, 100, 470);
    issue(4'b0100, 0);
    wait_idle();
    force0 = 1'b0;

    // Level change requested mid-probe is deferred past done.
    set_coord(3, 200, 260);
    issue(4'b1000, 0);
    s = m_done - 5;
    while (cyc < s + 2) @(negedge clk);
    level_pulse(2);
    check("level_held_probe", int'(level_id), 1);
    while (cyc < s + 5) @(negedge clk);
    check("level_held_done", int'(level_id), 1);
    set_coord(1, 120, 250);
    issue(4'b0010, 0);
    @(negedge clk);
    check("level_held_idle", int'(level_id), 1);
    check("no_grant_level_cycle", int'(grant), 0);
    @(negedge clk);
    check("level_now_2", int'(level_id), 2);
    wait_idle();

    // Reset during the second probe cycle aborts the query.
    repeat (2) @(negedge clk);
    set_coord(1, 50, 50);
    issue(4'b0010, 0);
    s = m_done - 5;
    void'(sb.pop_back());
    while (cyc < s + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    check("abort_grant", int'(grant), 0);
    check("abort_done", int'(done), 0);
    check("abort_hit", int'(hit), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_map_x", int'(map_x), 0);
    check("abort_map_y", int'(map_y), 0);
    check("abort_level", int'(level_id), 0);
    m_ptr = 0; m_level = 0; m_pend = 0; m_hitv = '0; m_done = cyc;
    repeat (5) @(negedge clk);

    // All requesters held: order 0,1,2,3,0 spaced six cycles apart.
    set_coord(0, 10, 100);
    set_coord(1, 200, 200);
    set_coord(2, 300, 10);
    set_coord(3, 620, 300);
    issue(4'b1111, 5);
    wait_idle();
    repeat (2) @(negedge clk);

    // Randomized single queries with occasional mid-probe level changes.
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      i = $urandom_range(0, N - 1);
      set_coord(i, $urandom_range(0, 660), $urandom_range(0, 500));
      issue(N'(1) << i, 0);
      if ($urandom_range(0, 3) == 0) begin
        s = m_done - 5;
        while (cyc < s + 2) @(negedge clk);
        level_pulse($urandom_range(0, 3));
      end
      wait_idle();
    end

    repeat (8) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
